// File: rtl/avalon_mem_responder.sv
// avalon_mem_responder: Avalon-MM 16-bit memory slave with pipelined reads; `WAIT_INJECT_EN adds LFSR stall injection
module avalon_mem_responder #(
  parameter int ADDR_BITS = 10,
  parameter int READ_LATENCY = 2,
  parameter int MAX_PENDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [25:0] s0_address,
  input  logic        s0_read_n,
  input  logic        s0_write_n,
  input  logic [15:0] s0_writedata,
  input  logic        s0_chipselect,
  input  logic [1:0]  s0_byteenable,
  output logic        s0_waitrequest,
  output logic        s0_readdatavalid,
  output logic [15:0] s0_readdata,
  output logic        err
);
  logic [15:0] mem [2**ADDR_BITS];
  logic [15:0] dat_q [READ_LATENCY];
  logic [READ_LATENCY-1:0] v_q, v_d;
  logic [2:0] pend_q, pend_d;
  logic err_q, err_d;
  logic [ADDR_BITS-1:0] idx;
  logic cmd, acc, wr_acc, rd_acc, rvalid, wait_w;
  logic unused_addr;
  assign unused_addr = ^s0_address[25:ADDR_BITS];
  assign idx = s0_address[ADDR_BITS-1:0];
  assign rvalid = v_q[READ_LATENCY-1];
`ifdef WAIT_INJECT_EN
  logic [7:0] lfsr_q, lfsr_d;
  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  always_ff @(posedge clk) lfsr_q <= rst ? 8'h01 : lfsr_d;
  assign wait_w = (pend_q == 3'(MAX_PENDING) && !rvalid) || lfsr_q[1:0] == 2'b00;
`else
  assign wait_w = pend_q == 3'(MAX_PENDING) && !rvalid;
`endif
  assign cmd = s0_chipselect && (!s0_read_n || !s0_write_n);
  assign acc = cmd && !wait_w;
  assign wr_acc = acc && !s0_write_n;
  // a read paired with a write is dropped and flagged
  assign rd_acc = acc && !s0_read_n && s0_write_n;
  always_comb begin
    v_d = v_q << 1;
    v_d[0] = rd_acc;
    pend_d = pend_q + 3'(rd_acc) - 3'(rvalid);
    err_d = err_q || (acc && !s0_read_n && !s0_write_n);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      pend_q <= '0;
      err_q <= 1'b0;
    end else begin
      v_q <= v_d;
      pend_q <= pend_d;
      err_q <= err_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_acc && s0_byteenable[1]) mem[idx][15:8] <= s0_writedata[15:8];
    if (wr_acc && s0_byteenable[0]) mem[idx][7:0] <= s0_writedata[7:0];
  end
  always_ff @(posedge clk) begin
    dat_q[0] <= mem[idx];
    for (int i = 1; i < READ_LATENCY; i++) dat_q[i] <= dat_q[i-1];
  end
  assign s0_waitrequest = wait_w;
  assign s0_readdatavalid = rvalid;
  assign s0_readdata = rvalid ? dat_q[READ_LATENCY-1] : 16'h0000;
  assign err = err_q;
endmodule

// File: doc/avalon_mem_responder.md
AVALON_MEM_RESPONDER -- requirements
Module: avalon_mem_responder

Interface
REQ-001 The block SHALL use one clock and one reset: clk, rst. rst is synchronous and active-high.
REQ-002 The block SHALL provide these parameters:
- ADDR_BITS, default 10, number of word-index bits used (memory depth 2**ADDR_BITS x 16).
- READ_LATENCY, default 2, legal range 1..4, cycles from read acceptance to readdatavalid.
- MAX_PENDING, default 2, legal range 1..4, maximum reads accepted but not yet returned.
REQ-003 The block SHALL provide these ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s0_address  in  26  word address
- s0_read_n  in  1  read strobe, active-low
- s0_write_n  in  1  write strobe, active-low
- s0_writedata  in  16  write data
- s0_chipselect  in  1  select, active-high
- s0_byteenable  in  2  byte lanes; bit1 = [15:8], bit0 = [7:0]
- s0_waitrequest  out  1  stall; a command presented while high is not accepted
- s0_readdatavalid  out  1  s0_readdata valid this cycle
- s0_readdata  out  16  read data
- err  out  1  sticky protocol error

Function
REQ-004 A command SHALL be present when s0_chipselect=1 and (s0_read_n=0 or s0_write_n=0), and accepted on a clk edge where it is present and s0_waitrequest=0.
REQ-005 The word index SHALL be s0_address[ADDR_BITS-1:0]; upper address bits are ignored, so addresses alias.
REQ-006 An accepted write SHALL update only the byte lanes enabled in s0_byteenable. byteenable=00 SHALL be accepted as a no-op.
REQ-007 When s0_read_n=0 and s0_write_n=0 are both asserted in an accepted command, the block SHALL perform the write only, drop the read, and set err=1 until reset.
REQ-008 An accepted read SHALL sample memory at the acceptance edge, after any write accepted on an earlier edge. A read accepted on the edge after a write to the same index SHALL return the new data.
REQ-009 s0_readdatavalid SHALL assert for exactly one cycle, exactly READ_LATENCY cycles after each read acceptance. Responses SHALL return in order through a READ_LATENCY-stage valid/data shift pipeline.
REQ-010 s0_readdata SHALL be 16'h0000 whenever s0_readdatavalid=0.
REQ-011 A pending counter SHALL track reads accepted but not yet returned:
- increment on read acceptance;
- decrement on the s0_readdatavalid cycle;
- hold when both occur in the same cycle.
REQ-012 s0_waitrequest SHALL assert when pending==MAX_PENDING and no read returns in that cycle. It SHALL be derived from registered state only, never combinationally from s0_* inputs.
REQ-013 While s0_waitrequest=1, reads and writes SHALL both be stalled. The stalled command SHALL be accepted on the first edge after waitrequest drops, provided the master still presents it.
REQ-014 Back-to-back reads SHALL be accepted at one per cycle when MAX_PENDING>=READ_LATENCY, giving sustained throughput of one response per cycle.

Reset
REQ-015 On rst=1 the block SHALL clear: s0_readdatavalid=0, s0_readdata=0, s0_waitrequest=0, err=0, pending=0, and every pipeline valid bit.
REQ-016 Reads in flight when rst asserts SHALL be discarded; no s0_readdatavalid SHALL appear for them after reset.
REQ-017 Memory contents SHALL NOT be cleared by rst.

Configuration
REQ-018 Macro WAIT_INJECT_EN, when defined, SHALL add stall injection:
- an 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, reset to 8'h01, advancing every cycle;
- s0_waitrequest additionally asserts whenever lfsr[1:0]==2'b00.
REQ-019 Without WAIT_INJECT_EN, no LFSR SHALL be present and s0_waitrequest SHALL follow REQ-012 only.

Verification
REQ-020 Write 16'hA5C3 at address 5 with byteenable=11, then read address 5 -> s0_readdatavalid exactly 2 cycles after read acceptance with 16'hA5C3.
REQ-021 Word at 5 holds 16'hA5C3; write 16'h1200 at address 5 with byteenable=10; read -> 16'h12C3. Then write with byteenable=00 and read -> still 16'h12C3.
REQ-022 Write 16'hBEEF at address 26'h0400 (aliases index 0), read address 0 -> 16'hBEEF.
REQ-023 Four reads presented on consecutive cycles with defaults (MAX_PENDING=2, READ_LATENCY=2) -> all four accepted at one per cycle, four consecutive readdatavalid pulses in order with correct data. Repeat with MAX_PENDING=1 -> waitrequest stalls alternate cycles, and still four in-order responses.
REQ-024 Command with read_n=0, write_n=0, data 16'h0F0F at address 3 -> word 3 becomes 16'h0F0F, no readdatavalid, err=1 held until rst.
REQ-025 Assert rst one cycle after a read is accepted -> no readdatavalid follows, and pending=0, waitrequest=0, err=0 after reset.
